// File: rtl/set_mode_controller.sv
// Set-mode controller for a clock display: RUN / SET_HRS / SET_MIN sequencing,
// increment auto-repeat, idle timeout back to RUN and digit blinking while setting.
module set_mode_controller #(
    parameter int BLINK_HALF  = 50000000,
    parameter int REPEAT_DLY  = 50000000,
    parameter int REPEAT_RATE = 20000000,
    parameter int TIMEOUT_S   = 10
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       sec_tick,
    output logic       run_en,
    output logic       inc_hrs,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [3:0] blank_mask,
    output logic [1:0] mode
);

    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int BLK_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int IDLE_W  = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HRS = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               mode_prev_q, mode_prev_d;
    logic               up_prev_q, up_prev_d;
    logic               inc_hrs_q, inc_hrs_d;
    logic               inc_min_q, inc_min_d;
    logic               clr_sec_q, clr_sec_d;
    logic               rpt_active_q, rpt_active_d;
    logic               rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               blink_q, blink_d;

    logic mode_edge, up_edge, in_set, fire;

    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_RUN;
            mode_prev_q  <= 1'b1;
            up_prev_q    <= 1'b1;
            inc_hrs_q    <= 1'b0;
            inc_min_q    <= 1'b0;
            clr_sec_q    <= 1'b0;
            rpt_active_q <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            blk_cnt_q    <= '0;
            blink_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_prev_q  <= mode_prev_d;
            up_prev_q    <= up_prev_d;
            inc_hrs_q    <= inc_hrs_d;
            inc_min_q    <= inc_min_d;
            clr_sec_q    <= clr_sec_d;
            rpt_active_q <= rpt_active_d;
            rpt_first_q  <= rpt_first_d;
            rpt_cnt_q    <= rpt_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            blink_q      <= blink_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_prev_d  = btn_mode;
        up_prev_d    = btn_up;
        inc_hrs_d    = 1'b0;
        inc_min_d    = 1'b0;
        clr_sec_d    = 1'b0;
        rpt_active_d = rpt_active_q;
        rpt_first_d  = rpt_first_q;
        rpt_cnt_d    = rpt_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        blink_d      = blink_q;
        fire         = 1'b0;

        mode_edge = btn_mode & ~mode_prev_q;
        up_edge   = btn_up & ~up_prev_q;
        in_set    = (state_q == ST_SET_HRS) || (state_q == ST_SET_MIN);

        case (state_q)
            ST_RUN:     if (mode_edge) state_d = ST_SET_HRS;
            ST_SET_HRS: if (mode_edge) state_d = ST_SET_MIN;
            ST_SET_MIN: if (mode_edge) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase

        // rpt_cnt_q holds cycles since the last pulse decision, starting at 1
        if (!in_set || mode_edge || !btn_up) begin
            rpt_active_d = 1'b0;
            rpt_first_d  = 1'b0;
            rpt_cnt_d    = '0;
        end else if (up_edge) begin
            fire         = 1'b1;
            rpt_active_d = 1'b1;
            rpt_first_d  = 1'b1;
            rpt_cnt_d    = RPT_W'(1);
        end else if (rpt_active_q) begin
            if (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DLY) : RPT_W'(REPEAT_RATE))) begin
                fire        = 1'b1;
                rpt_first_d = 1'b0;
                rpt_cnt_d   = RPT_W'(1);
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end

        inc_hrs_d = fire && (state_q == ST_SET_HRS);
        inc_min_d = fire && (state_q == ST_SET_MIN);

        if (!in_set || mode_edge || up_edge || fire) begin
            idle_cnt_d = '0;
        end else if (sec_tick) begin
            if (idle_cnt_q + 1'b1 == IDLE_W'(TIMEOUT_S)) begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end

        clr_sec_d = in_set && (state_d == ST_RUN);

        if (state_d == ST_RUN || state_d != state_q || fire) begin
            blk_cnt_d = '0;
            blink_d   = 1'b0;
        end else if (blk_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
            blk_cnt_d = '0;
            blink_d   = ~blink_q;
        end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
        end
    end

    always_comb begin
        run_en     = 1'b1;
        blank_mask = 4'b0000;
        case (state_q)
            ST_SET_HRS: begin
                run_en     = 1'b0;
                blank_mask = {blink_q, blink_q, 2'b00};
            end
            ST_SET_MIN: begin
                run_en     = 1'b0;
                blank_mask = {2'b00, blink_q, blink_q};
            end
            default: ;
        endcase
    end

    assign mode    = state_q;
    assign inc_hrs = inc_hrs_q;
    assign inc_min = inc_min_q;
    assign clr_sec = clr_sec_q;

endmodule

// File: tb/tb_set_mode_controller.sv
// Directed bench for set_mode_controller with small timing parameters; expected
// outputs are queued per step and compared once the DUT has clocked.
module tb_set_mode_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       sec_tick = 1'b0;
    logic       run_en, inc_hrs, inc_min, clr_sec;
    logic [3:0] blank_mask;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] mode;
        logic       inc_hrs;
        logic       inc_min;
        logic       clr_sec;
        logic [3:0] blank;
    } exp_t;

    exp_t exp_q[$];

    set_mode_controller #(
        .BLINK_HALF (4),
        .REPEAT_DLY (8),
        .REPEAT_RATE(3),
        .TIMEOUT_S  (2)
    ) dut (
        .CLK100MHZ (clk),
        .Reset     (rst),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .sec_tick  (sec_tick),
        .run_en    (run_en),
        .inc_hrs   (inc_hrs),
        .inc_min   (inc_min),
        .clr_sec   (clr_sec),
        .blank_mask(blank_mask),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_blank(input int m, input int j);
        logic b;
        b = ((j / 4) % 2) == 1;
        if (m == 1) return b ? 4'b1100 : 4'b0000;
        if (m == 2) return b ? 4'b0011 : 4'b0000;
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input string field, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int m, input logic ih, input logic im,
                        input logic cs, input logic [3:0] bl);
        exp_t e;
        e.tag = tag; e.mode = 2'(m); e.inc_hrs = ih; e.inc_min = im; e.clr_sec = cs; e.blank = bl;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        e = exp_q.pop_front();
        chk(e.tag, "mode",   {2'b00, mode},    {2'b00, e.mode});
        chk(e.tag, "run_en", {3'b000, run_en}, {3'b000, (e.mode == 2'b00)});
        chk(e.tag, "inc_hrs", {3'b000, inc_hrs}, {3'b000, e.inc_hrs});
        chk(e.tag, "inc_min", {3'b000, inc_min}, {3'b000, e.inc_min});
        chk(e.tag, "clr_sec", {3'b000, clr_sec}, {3'b000, e.clr_sec});
        chk(e.tag, "blank",  blank_mask,       e.blank);
    endtask

    // Drive inputs for one cycle, queue the expected post-edge outputs, then compare.
    task automatic step(input logic bm, input logic bu, input logic st, input string tag,
                        input int m, input logic ih, input logic im, input logic cs,
                        input logic [3:0] bl);
        btn_mode = bm; btn_up = bu; sec_tick = st;
        push(tag, m, ih, im, cs, bl);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    initial begin
        int  last;
        logic ie;

        #2;
        push("reset", 0, 0, 0, 0, 4'b0000);
        pop_compare();

        btn_mode = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, "hold_thru_rst", 0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, "hold_release", 0, 0, 0, 0, 4'b0000);

        step(1, 0, 0, "press1", 1, 0, 0, 0, 4'b0000);
        step(0, 0, 0, "rel1",   1, 0, 0, 0, 4'b0000);
        step(1, 0, 0, "press2", 2, 0, 0, 0, 4'b0000);
        step(0, 0, 0, "rel2",   2, 0, 0, 0, 4'b0000);
        step(1, 0, 0, "press3", 0, 0, 0, 1, 4'b0000);
        step(0, 0, 0, "rel3",   0, 0, 0, 0, 4'b0000);

        step(1, 0, 0, "blink_entry", 1, 0, 0, 0, 4'b0000);
        for (int j = 1; j <= 4; j++) step(0, 0, 0, "blink_hrs", 1, 0, 0, 0, exp_blank(1, j));
        step(0, 1, 0, "inc_restart", 1, 1, 0, 0, 4'b0000);
        for (int j = 1; j <= 5; j++) step(0, 0, 0, "blink_after_inc", 1, 0, 0, 0, exp_blank(1, j));

        step(1, 1, 0, "coincident", 2, 0, 0, 0, 4'b0000);
        for (int j = 1; j <= 10; j++) step(0, 1, 0, "coinc_hold", 2, 0, 0, 0, exp_blank(2, j));
        step(0, 0, 0, "coinc_release", 2, 0, 0, 0, exp_blank(2, 11));

        last = 0;
        for (int i = 0; i < 16; i++) begin
            ie = (i == 0) || (i == 8) || (i == 11) || (i == 14);
            if (ie) last = i;
            step(0, 1, 0, "repeat_min", 2, 0, ie, 0, exp_blank(2, i - last));
        end
        step(0, 0, 0, "repeat_release", 2, 0, 0, 0, exp_blank(2, 16 - last));

        step(1, 0, 0, "to_run", 0, 0, 0, 1, 4'b0000);
        step(0, 0, 0, "run_idle", 0, 0, 0, 0, 4'b0000);
        step(1, 0, 0, "to_hrs", 1, 0, 0, 0, 4'b0000);
        step(0, 0, 1, "tick1", 1, 0, 0, 0, 4'b0000);
        step(0, 0, 0, "tick_gap", 1, 0, 0, 0, 4'b0000);
        step(0, 0, 1, "timeout", 0, 0, 0, 1, 4'b0000);
        step(0, 0, 0, "after_timeout", 0, 0, 0, 0, 4'b0000);

        step(1, 0, 0, "rr_hrs", 1, 0, 0, 0, 4'b0000);
        step(0, 0, 0, "rr_hrs_rel", 1, 0, 0, 0, 4'b0000);
        step(1, 0, 0, "rr_min", 2, 0, 0, 0, 4'b0000);
        step(0, 0, 0, "rr_min_rel", 2, 0, 0, 0, exp_blank(2, 1));
        for (int i = 0; i <= 8; i++)
            step(0, 1, 0, "rr_repeat", 2, 0, (i == 0) || (i == 8), 0, exp_blank(2, (i < 8) ? i : 0));
        rst = 1'b1;
        #1;
        push("rst_mid_repeat", 0, 0, 0, 0, 4'b0000);
        pop_compare();
        step(0, 1, 0, "rst_held", 0, 0, 0, 0, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(0, 1, 0, "post_rst_hold", 0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, "post_rst_rel", 0, 0, 0, 0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
